arc4_crack_ctrl: RTL and testbench
==================================

// Module: arc4_crack_ctrl
// PURPOSE
//  Brute-force key-search sequencer for the ARC4 decryption core. Steps a 24-bit
//  key through a range and launches arc4 once per key via its rdy/en handshake.
//  After each decryption it scans the plaintext memory for an all-printable
//  message, and stops on the first hit or when the range is exhausted.
//  Sits between the top level (start/result) and one arc4 instance plus its pt_mem.
//  It owns the pt_mem read port while scanning.
// PARAMETERS
//  KEY_START  24'h000000  first key tried
//  KEY_STEP   1           key increment per attempt (2 = odd/even split for dual-core)
//  KEY_LAST   24'hFFFFFF  last key allowed; the search fails after this key is rejected
// PORTS
//  CLOCK_50     in   1   system clock
//  rst_n        in   1   synchronous active-low reset
//  start        in   1   pulse; begins a search when idle (ignored otherwise)
//  busy         out  1   high from accepted start until done
//  done         out  1   high once the search ends; held until the next start or reset
//  key_valid    out  1   with done: 1 = key found, 0 = range exhausted
//  key_found    out  24  key under test / final key (valid when done & key_valid)
//  a4_en        out  1   one-cycle launch pulse to arc4.en
//  a4_rdy       in   1   arc4.rdy
//  a4_key       out  24  key presented to arc4.key; stable from launch to rdy re-assert
//  a4_pt_addr   in   8   arc4 pt address (passed through when not scanning)
//  a4_pt_wrdata in   8   arc4 pt write data (passed through)
//  a4_pt_wren   in   1   arc4 pt write enable (passed through)
//  pt_addr      out  8   to pt_mem.address
//  pt_wrdata    out  8   to pt_mem.data
//  pt_wren      out  1   to pt_mem.wren
//  pt_rddata    in   8   pt_mem.q; 1-cycle read latency (registered address)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, key_valid=0, a4_en=0, key_found=KEY_START.
//   Reset mid-search abandons the search at once; arc4 shares rst_n.
//  FSM:
//   IDLE: start=1 -> key<=KEY_START, done<=0, key_valid<=0, go to LAUNCH.
//   LAUNCH: wait a4_rdy=1; assert a4_en for exactly 1 cycle; go to WAIT_BUSY.
//   WAIT_BUSY: wait for a4_rdy=0, which arc4 drops the cycle after en.
//   WAIT_DONE: wait for a4_rdy=1; then go to RD_LEN.
//   RD_LEN: pt_addr=0. Next cycle latch len=pt_rddata and set idx=1.
//    len=0 -> REJECT.
//   SCAN: pt_addr=idx each cycle, pipelined. Check byte k in the cycle after its
//    address. Byte must be 0x20..0x7E, else REJECT. Last byte (idx=len) ok -> FOUND.
//   REJECT: if key > KEY_LAST-KEY_STEP or key+KEY_STEP overflows 24 bits -> FAIL;
//    else key<=key+KEY_STEP, go to LAUNCH.
//   FOUND: done<=1, key_valid<=1, key_found=key; go to IDLE.
//   FAIL: done<=1, key_valid<=0; go to IDLE.
//  pt mux: in RD_LEN/SCAN, pt_addr is driven by the ctrl and pt_wren=0.
//   In all other states, pt_addr/pt_wrdata/pt_wren = the a4_* inputs.
//  busy = state != IDLE. start while busy is ignored. start in the same cycle as
//   done rising is ignored.
//  Scan per key costs len+2 cycles worst case; it stops at the first bad byte.
//  a4_key = current key register; it changes only in REJECT.
// TESTING
//  1. ct = "msg" encrypted with key 24'h000018, KEY_START=0 -> 25 launches;
//     done=1, key_valid=1, key_found=24'h000018.
//  2. KEY_START=0, KEY_LAST=3, ct decrypting non-printable for all keys -> 4 launches;
//     done=1, key_valid=0.
//  3. KEY_STEP=2, KEY_START=1, key 24'h000018 -> never tried; KEY_LAST=31 -> key_valid=0.
//     Key 24'h000019 -> found after 13 launches.
//  4. Decrypted len byte=0 for key 0, valid message for key 1 -> key 0 rejected,
//     key_found=1.
//  5. rst_n low for 1 cycle during SCAN -> busy=0, done=0 next cycle; new start reruns
//     from KEY_START.
//  6. Extra start pulses during WAIT_DONE -> no effect; exactly one a4_en pulse per key.
//     pt_wren=0 throughout scan.

Source files
------------

// File: rtl/arc4_crack_ctrl.sv
// -----------------------------------------------------------------------------
// arc4_crack_ctrl
//  Brute-force key-search sequencer for one ARC4 decryption core. Walks a
//  24-bit key from KEY_START in KEY_STEP increments up to KEY_LAST, launches
//  arc4 once per key through its rdy/en handshake, then scans the
//  length-prefixed plaintext in pt_mem for an all-printable (0x20..0x7E)
//  message. It stops on the first hit or when the range is exhausted.
//
// Ports
//  CLOCK_50      system clock
//  rst_n         synchronous active-low reset (shared with arc4)
//  start         begins a search when idle; ignored while busy
//  busy          high from accepted start until done
//  done          search finished; held until the next start or reset
//  key_valid     with done: 1 = key found, 0 = range exhausted
//  key_found     key under test / final key
//  a4_en         one-cycle launch pulse to arc4
//  a4_rdy        arc4 ready
//  a4_key        key presented to arc4; changes only between attempts
//  a4_pt_*       arc4 plaintext-memory port, passed through when not scanning
//  pt_*          plaintext-memory port (1-cycle read latency)
// -----------------------------------------------------------------------------
module arc4_crack_ctrl #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter int unsigned KEY_STEP  = 1,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        key_valid,
    output logic [23:0] key_found,
    output logic        a4_en,
    input  logic        a4_rdy,
    output logic [23:0] a4_key,
    input  logic [7:0]  a4_pt_addr,
    input  logic [7:0]  a4_pt_wrdata,
    input  logic        a4_pt_wren,
    output logic [7:0]  pt_addr,
    output logic [7:0]  pt_wrdata,
    output logic        pt_wren,
    input  logic [7:0]  pt_rddata
);

    localparam int unsigned KEY_W  = 24;
    localparam int unsigned KEY_NW = KEY_W + 1;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] PRINT_LO = 8'h20;
    localparam logic [DATA_W-1:0] PRINT_HI = 8'h7E;

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RD_LEN,
        SCAN,
        REJECT,
        FOUND,
        FAIL
    } state_t;

    state_t              state_q;
    logic [KEY_W-1:0]    key_q;
    logic                busy_q;
    logic                done_q;
    logic                valid_q;
    logic                en_q;
    logic                len_phase_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   len_q;

    logic [KEY_NW-1:0]   key_next;
    logic                range_end;
    logic                byte_ok;

    // Next key computed one bit wider so a 24-bit wrap also ends the range.
    assign key_next  = {1'b0, key_q} + KEY_NW'(KEY_STEP);
    assign range_end = key_next > {1'b0, KEY_LAST};
    assign byte_ok   = (pt_rddata >= PRINT_LO) && (pt_rddata <= PRINT_HI);

    // Search sequencer.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_q       <= KEY_START;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            en_q        <= 1'b0;
            len_phase_q <= 1'b0;
            addr_q      <= '0;
            idx_q       <= '0;
            len_q       <= '0;
        end else begin
            en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q   <= KEY_START;
                        done_q  <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (a4_rdy) begin
                        en_q    <= 1'b1;
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // rdy still reads high during the en cycle itself.
                    if (!a4_rdy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (a4_rdy) begin
                        addr_q      <= '0;
                        len_phase_q <= 1'b0;
                        state_q     <= RD_LEN;
                    end
                end
                RD_LEN: begin
                    if (!len_phase_q) begin
                        // Address 0 is in flight; start fetching byte 1 already.
                        len_phase_q <= 1'b1;
                        addr_q      <= ADDR_W'(1);
                    end else begin
                        len_q   <= pt_rddata;
                        idx_q   <= ADDR_W'(1);
                        addr_q  <= ADDR_W'(2);
                        state_q <= (pt_rddata == '0) ? REJECT : SCAN;
                    end
                end
                SCAN: begin
                    // pt_rddata holds byte idx_q; address idx_q+1 is in flight.
                    if (!byte_ok) begin
                        state_q <= REJECT;
                    end else if (idx_q == len_q) begin
                        state_q <= FOUND;
                    end else begin
                        idx_q  <= idx_q + ADDR_W'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                REJECT: begin
                    if (range_end) begin
                        state_q <= FAIL;
                    end else begin
                        key_q   <= key_next[KEY_W-1:0];
                        state_q <= LAUNCH;
                    end
                end
                FOUND: begin
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                FAIL: begin
                    done_q  <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Plaintext-memory port: ours while reading, arc4's otherwise.
    always_comb begin
        pt_addr   = a4_pt_addr;
        pt_wrdata = a4_pt_wrdata;
        pt_wren   = a4_pt_wren;
        if ((state_q == RD_LEN) || (state_q == SCAN)) begin
            pt_addr = addr_q;
            pt_wren = 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = valid_q;
    assign key_found = key_q;
    assign a4_en     = en_q;
    assign a4_key    = key_q;

endmodule

// File: tb/tb_arc4_crack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arc4_crack_ctrl
//  Three controller instances (different key ranges) share one behavioural
//  arc4 model and one pt_mem; only the selected instance is started. The arc4
//  model writes an 8-byte length-prefixed plaintext whose content depends on
//  the launched key. Expected launch keys and search results are queued when a
//  search is started and popped as the DUT launches / finishes.
// -----------------------------------------------------------------------------
module tb_arc4_crack_ctrl;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_n;
    logic        start_v   [3];
    logic        busy_v    [3];
    logic        done_v    [3];
    logic        valid_v   [3];
    logic        en_v      [3];
    logic [23:0] keyf_v    [3];
    logic [23:0] a4key_v   [3];
    logic [7:0]  ptaddr_v  [3];
    logic [7:0]  ptwd_v    [3];
    logic        ptwren_v  [3];

    logic        m_rdy;
    logic [23:0] m_key;
    int          m_cnt;
    logic [7:0]  m_addr;
    logic [7:0]  m_wd;
    logic        m_wren;
    logic [7:0]  rddata;
    logic [7:0]  mem [256];

    int          sel = 0;
    logic [23:0] good_key = 24'h000018;
    bit          good_en = 1'b1;
    bit          zero0 = 1'b0;

    logic        en_s;
    logic        pt_wren_s;
    logic [23:0] a4key_s;
    logic [7:0]  pt_addr_s;
    logic [7:0]  pt_wd_s;

    assign en_s      = en_v[sel];
    assign pt_wren_s = ptwren_v[sel];
    assign a4key_s   = a4key_v[sel];
    assign pt_addr_s = ptaddr_v[sel];
    assign pt_wd_s   = ptwd_v[sel];

    arc4_crack_ctrl #(.KEY_START(24'h000000), .KEY_STEP(1), .KEY_LAST(24'hFFFFFF)) dut_a (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .key_valid(valid_v[0]), .key_found(keyf_v[0]), .a4_en(en_v[0]), .a4_rdy(m_rdy),
        .a4_key(a4key_v[0]), .a4_pt_addr(m_addr), .a4_pt_wrdata(m_wd), .a4_pt_wren(m_wren),
        .pt_addr(ptaddr_v[0]), .pt_wrdata(ptwd_v[0]), .pt_wren(ptwren_v[0]), .pt_rddata(rddata));

    arc4_crack_ctrl #(.KEY_START(24'h000000), .KEY_STEP(1), .KEY_LAST(24'h000003)) dut_b (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .key_valid(valid_v[1]), .key_found(keyf_v[1]), .a4_en(en_v[1]), .a4_rdy(m_rdy),
        .a4_key(a4key_v[1]), .a4_pt_addr(m_addr), .a4_pt_wrdata(m_wd), .a4_pt_wren(m_wren),
        .pt_addr(ptaddr_v[1]), .pt_wrdata(ptwd_v[1]), .pt_wren(ptwren_v[1]), .pt_rddata(rddata));

    arc4_crack_ctrl #(.KEY_START(24'h000001), .KEY_STEP(2), .KEY_LAST(24'h00001F)) dut_c (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .key_valid(valid_v[2]), .key_found(keyf_v[2]), .a4_en(en_v[2]), .a4_rdy(m_rdy),
        .a4_key(a4key_v[2]), .a4_pt_addr(m_addr), .a4_pt_wrdata(m_wd), .a4_pt_wren(m_wren),
        .pt_addr(ptaddr_v[2]), .pt_wrdata(ptwd_v[2]), .pt_wren(ptwren_v[2]), .pt_rddata(rddata));

    // Decrypted plaintext for a key: one good message, otherwise rejects of
    // various kinds (boundary bytes 0x1F/0x7F/0x80, bad last byte, len 0).
    function automatic logic [7:0] pt_byte(input logic [23:0] k, input int i);
        logic [7:0] m [8];
        if (good_en && k == good_key)
            m = '{8'd5, 8'h20, 8'h6D, 8'h73, 8'h67, 8'h7E, 8'h00, 8'h00};
        else if (zero0 && k == 24'd0)
            m = '{8'd0, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
        else begin
            case (k[1:0])
                2'd0:    m = '{8'd3, 8'h1F, 8'h41, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00};
                2'd1:    m = '{8'd3, 8'h41, 8'h7F, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
                2'd2:    m = '{8'd4, 8'h20, 8'h7E, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
                default: m = '{8'd2, 8'h61, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
            endcase
        end
        return m[i];
    endfunction

    // pt_mem: registered address, 1-cycle read latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h41;
        end else if (pt_wren_s) begin
            mem[pt_addr_s] <= pt_wd_s;
        end
        rddata <= mem[pt_addr_s];
    end

    // arc4 model: drops rdy the cycle after en, writes 8 bytes, raises rdy.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_rdy <= 1'b1; m_cnt <= 0; m_wren <= 1'b0;
            m_key <= '0; m_addr <= '0; m_wd <= '0;
        end else if (m_rdy) begin
            m_wren <= 1'b0;
            if (en_s) begin
                m_rdy <= 1'b0; m_key <= a4key_s; m_cnt <= 0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt >= 2 && m_cnt < 10) begin
                m_wren <= 1'b1;
                m_addr <= 8'(m_cnt - 2);
                m_wd   <= pt_byte(m_key, m_cnt - 2);
            end else begin
                m_wren <= 1'b0;
            end
            if (m_cnt == 11) m_rdy <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int n_launch = 0;
    int viol = 0;

    typedef struct {
        logic        valid;
        logic [23:0] key;
        int          launches;
    } res_t;

    logic [23:0] exp_keys [$];
    res_t        res_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch scoreboard and port-protocol monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (en_s) begin
                if (!m_rdy) viol++;
                else begin
                    n_launch++;
                    if (exp_keys.size() == 0) viol++;
                    else check_eq("launch_key", 32'(a4key_s), 32'(exp_keys.pop_front()));
                end
            end
            if (pt_wren_s !== m_wren) viol++;
            if (m_wren && pt_addr_s !== m_addr) viol++;
            if (!m_rdy && a4key_s !== m_key) viol++;
        end
    end

    task automatic search(input int s, input logic [23:0] first, input int step, input int nk,
                          input bit exp_valid, input logic [23:0] exp_key, input bit extra);
        res_t r;
        int   cyc;
        sel = s;
        exp_keys.delete();
        for (int i = 0; i < nk; i++) exp_keys.push_back(24'(first + 24'(i * step)));
        r.valid = exp_valid; r.key = exp_key; r.launches = nk;
        res_q.push_back(r);
        n_launch = 0; viol = 0;
        @(negedge clk); start_v[s] = 1'b1;
        @(negedge clk); start_v[s] = 1'b0;
        check_eq("busy_after_start", 32'(busy_v[s]), 32'd1);
        check_eq("done_cleared", 32'(done_v[s]), 32'd0);
        cyc = 0;
        while (done_v[s] !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start_v[s] = extra && !m_rdy && (m_cnt == 5);
        end
        start_v[s] = 1'b0;
        check_eq("search_done", 32'(done_v[s]), 32'd1);
        r = res_q.pop_front();
        check_eq("key_valid", 32'(valid_v[s]), 32'(r.valid));
        if (r.valid) check_eq("key_found", 32'(keyf_v[s]), 32'(r.key));
        check_eq("busy_at_done", 32'(busy_v[s]), 32'd0);
        check_eq("launch_count", 32'(n_launch), 32'(r.launches));
        check_eq("keys_left", 32'(exp_keys.size()), 32'd0);
        check_eq("protocol_viol", 32'(viol), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("done_held", 32'(done_v[s]), 32'd1);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_busy", 32'(busy_v[i]), 32'd0);
            check_eq("rst_done", 32'(done_v[i]), 32'd0);
            check_eq("rst_valid", 32'(valid_v[i]), 32'd0);
            check_eq("rst_en", 32'(en_v[i]), 32'd0);
        end
        check_eq("rst_key_a", 32'(keyf_v[0]), 32'h0);
        check_eq("rst_key_c", 32'(keyf_v[2]), 32'h1);

        // Key 0x18 found after 25 launches; stray starts while arc4 is busy.
        good_en = 1'b1; good_key = 24'h000018; zero0 = 1'b0;
        search(0, 24'h0, 1, 25, 1'b1, 24'h000018, 1'b1);

        // Range 0..3 with no good key: exhausted after 4 launches.
        good_en = 1'b0;
        search(1, 24'h0, 1, 4, 1'b0, 24'h0, 1'b0);

        // Odd keys only: 0x18 never tried, 0x19 found after 13 launches.
        good_en = 1'b1; good_key = 24'h000018;
        search(2, 24'h1, 2, 16, 1'b0, 24'h0, 1'b0);
        good_key = 24'h000019;
        search(2, 24'h1, 2, 13, 1'b1, 24'h000019, 1'b0);

        // Zero-length message for key 0 is rejected; key 1 is good.
        zero0 = 1'b1; good_key = 24'h000001;
        search(0, 24'h0, 1, 2, 1'b1, 24'h000001, 1'b0);

        // Reset in the middle of scanning key 0, then a clean rerun.
        zero0 = 1'b0; good_key = 24'h000018;
        sel = 0;
        exp_keys.delete();
        exp_keys.push_back(24'h0);
        n_launch = 0;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        cyc = 0;
        while (!(m_rdy === 1'b1 && n_launch == 1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("first_decrypt_done", 32'(n_launch), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midscan_rst_busy", 32'(busy_v[0]), 32'd0);
        check_eq("midscan_rst_done", 32'(done_v[0]), 32'd0);
        check_eq("midscan_rst_key", 32'(keyf_v[0]), 32'h0);
        search(0, 24'h0, 1, 25, 1'b1, 24'h000018, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
